// File: rtl/tpu_host_ctrl.sv
// Host-side command decoder for the 2x2 int8 systolic array: operand registers,
// compute-run sequencing with timeout, result capture and byte-wide read-back.
module tpu_host_ctrl #(
    parameter int ACC_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         ui_in,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uo_out,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic [31:0]        arr_w,
    output logic [31:0]        arr_a,
    output logic               arr_start,
    input  logic               arr_done,
    input  logic [4*ACC_W-1:0] arr_result
);

    localparam int RES_W  = 4 * ACC_W;
    localparam int NBYTES = RES_W / 8;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [2:0] OP_LOAD_W = 3'b001;
    localparam logic [2:0] OP_LOAD_A = 3'b010;
    localparam logic [2:0] OP_START  = 3'b011;
    localparam logic [2:0] OP_READ   = 3'b100;
    localparam logic [2:0] OP_CLEAR  = 3'b101;
    localparam logic [2:0] OP_STATUS = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [RES_W-1:0] result_reg, result_n;
    logic [31:0]      w_n, a_n;
    logic [7:0]       uo_n;
    logic             start_n, done, done_n, err, err_n;
    logic             cmd_acc, busy;
    logic [2:0]       opcode, idx;
    logic             unused_ui_bit;

    assign cmd_acc       = ena & ui_in[7];
    assign opcode        = ui_in[6:4];
    assign idx           = ui_in[2:0];
    assign busy          = (state == S_RUN);
    assign unused_ui_bit = ui_in[3];
    assign uio_out       = 8'h00;
    assign uio_oe        = 8'h00;

    // Little-endian byte of the result tile; indices past the tile read as zero.
    function automatic logic [7:0] read_byte(input logic [RES_W-1:0] r, input logic [2:0] i);
        if (int'(i) >= NBYTES)
            return 8'h00;
        return r[8*int'(i) +: 8];
    endfunction

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        result_n = result_reg;
        w_n      = arr_w;
        a_n      = arr_a;
        uo_n     = uo_out;
        start_n  = 1'b0;
        done_n   = done;
        err_n    = err;

        // arr_done is checked before the timeout so a simultaneous finish still counts.
        if (state == S_RUN) begin
            if (arr_done) begin
                state_n  = S_DONE;
                result_n = arr_result;
                done_n   = 1'b1;
            end else if (cnt == TIMEOUT_CNT) begin
                state_n = S_ERR;
                err_n   = 1'b1;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end

        if (cmd_acc) begin
            case (opcode)
                OP_LOAD_W: if (!busy) begin
                    w_n[8*int'(idx[1:0]) +: 8] = uio_in;
                    done_n = 1'b0;
                end
                OP_LOAD_A: if (!busy) begin
                    a_n[8*int'(idx[1:0]) +: 8] = uio_in;
                    done_n = 1'b0;
                end
                OP_START: if (!busy) begin
                    state_n = S_RUN;
                    start_n = 1'b1;
                    cnt_n   = 8'd0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end
                OP_READ:   uo_n = read_byte(result_reg, idx);
                OP_CLEAR: begin
                    state_n  = S_IDLE;
                    done_n   = 1'b0;
                    err_n    = 1'b0;
                    result_n = '0;
                end
                OP_STATUS: uo_n = {busy, done, err, 5'b0};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            result_reg <= '0;
            arr_w      <= 32'd0;
            arr_a      <= 32'd0;
            uo_out     <= 8'h00;
            arr_start  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            result_reg <= result_n;
            arr_w      <= w_n;
            arr_a      <= a_n;
            uo_out     <= uo_n;
            arr_start  <= start_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Bench for tpu_host_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_tpu_host_ctrl;

    localparam int ACC_W = 16;
    localparam int TO    = 12;
    localparam int NB    = 4 * ACC_W / 8;

    localparam logic [2:0] NOP = 3'd0, LOADW = 3'd1, LOADA = 3'd2, START = 3'd3;
    localparam logic [2:0] READ = 3'd4, CLEAR = 3'd5, STATUS = 3'd6;

    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [7:0]  ui_in = 8'h00, uio_in = 8'h00;
    logic [7:0]  uo_out, uio_out, uio_oe;
    logic [31:0] arr_w, arr_a;
    logic        arr_start;
    logic        arr_done = 1'b0;
    logic [63:0] stub_result = 64'd0;

    tpu_host_ctrl #(.ACC_W(ACC_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .arr_w(arr_w), .arr_a(arr_a), .arr_start(arr_start),
        .arr_done(arr_done), .arr_result(stub_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Array stub: done a programmable number of cycles after arr_start (0 = never).
    int stub_delay = 3, stub_cnt = 0;
    bit stub_noise = 0, rand_res = 0;
    always @(negedge clk) begin
        arr_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) arr_done = 1'b1;
        end
        if (stub_noise && $urandom_range(0, 19) == 0) arr_done = 1'b1;
        if (arr_start === 1'b1) begin
            stub_cnt = (stub_delay > 0) ? stub_delay : 0;
            if (rand_res) stub_result = {$urandom, $urandom};
        end
    end

    // Behavioural model: flags plus the edge number at which the run began.
    logic        m_run, m_done, m_err, m_start;
    logic [63:0] m_res;
    logic [7:0]  m_uo;
    logic [7:0]  m_w[4], m_a[4];
    int          edge_no = 0, start_edge = 0, start_count = 0;

    task automatic model_step();
        logic was_run, old_done, old_err, cmd;
        logic [63:0] old_res;
        logic [2:0] op, ix;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_err = 0; m_start = 0; m_res = 0; m_uo = 0;
            for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_a[i] = 0; end
            return;
        end
        edge_no++;
        was_run = m_run; old_done = m_done; old_err = m_err; old_res = m_res;
        cmd = ena && ui_in[7];
        op = ui_in[6:4];
        ix = ui_in[2:0];
        m_start = 0;
        if (cmd && op == CLEAR) begin
            m_run = 0; m_done = 0; m_err = 0; m_res = 0;
        end else begin
            if (was_run) begin
                if (arr_done) begin
                    m_res = stub_result; m_done = 1; m_run = 0;
                end else if (edge_no - start_edge == TO + 1) begin
                    m_err = 1; m_run = 0;
                end
            end
            if (cmd) begin
                case (op)
                    LOADW: if (!was_run) begin m_w[ix % 4] = uio_in; m_done = 0; end
                    LOADA: if (!was_run) begin m_a[ix % 4] = uio_in; m_done = 0; end
                    START: if (!was_run) begin
                        m_run = 1; start_edge = edge_no; m_done = 0; m_err = 0; m_start = 1;
                    end
                    READ:   m_uo = (int'(ix) < NB) ? 8'(old_res >> (8 * int'(ix))) : 8'h00;
                    STATUS: m_uo = {was_run, old_done, old_err, 5'b0};
                    default: ;
                endcase
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("uo_out", uo_out, m_uo);
        check("arr_w", arr_w, {m_w[3], m_w[2], m_w[1], m_w[0]});
        check("arr_a", arr_a, {m_a[3], m_a[2], m_a[1], m_a[0]});
        check("arr_start", arr_start, m_start);
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);
        if (arr_start === 1'b1) start_count++;
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] ix, input logic [7:0] d);
        @(negedge clk);
        ui_in  = {1'b1, op, 1'b0, ix};
        uio_in = d;
        @(negedge clk);
        ui_in  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_rd[8];
        int rec;
        exp_rd = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};

        ena = 1'b1;
        idle(2);
        check("reset_uo", uo_out, 8'h00);
        check("reset_w", arr_w, 32'h0);
        check("reset_a", arr_a, 32'h0);
        check("reset_start", arr_start, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        issue(STATUS, 0, 0);
        check("status_after_reset", uo_out, 8'h00);

        issue(LOADW, 0, 8'h01); issue(LOADW, 1, 8'h00);
        issue(LOADW, 2, 8'h00); issue(LOADW, 3, 8'h01);
        for (int i = 0; i < 4; i++) issue(LOADA, 3'(i), 8'(i + 1));
        check("weights", arr_w, 32'h01000001);
        check("acts", arr_a, 32'h04030201);

        stub_delay = 3;
        stub_result = 64'h0004_0003_0002_0001;
        rec = start_count;
        issue(START, 0, 0);
        issue(STATUS, 0, 0);
        check("status_run", uo_out, 8'h80);
        idle(4);
        check("start_pulses", 64'(start_count - rec), 1);
        for (int i = 0; i < 8; i++) begin
            issue(READ, 3'(i), 0);
            check("read_byte", uo_out, exp_rd[i]);
        end
        issue(STATUS, 0, 0);
        check("status_done", uo_out, 8'h40);

        stub_delay = 0;
        issue(START, 0, 0);
        issue(LOADW, 0, 8'hAA);
        check("loadw_in_run", arr_w, 32'h01000001);
        idle(TO + 3);
        issue(STATUS, 0, 0);
        check("status_timeout", uo_out, 8'h20);
        issue(CLEAR, 0, 0);
        issue(STATUS, 0, 0);
        check("status_clear", uo_out, 8'h00);
        issue(READ, 0, 0);
        check("read_after_clear", uo_out, 8'h00);

        @(negedge clk);
        ena = 1'b0; ui_in = {1'b1, LOADW, 4'd0}; uio_in = 8'hFF;
        idle(3);
        ui_in = 8'h00; ena = 1'b1;
        check("ena_low_load", arr_w, 32'h01000001);

        stub_delay = 3;
        rec = start_count;
        @(negedge clk) ui_in = {1'b1, START, 4'd0};
        @(negedge clk);
        @(negedge clk) ui_in = 8'h00;
        idle(6);
        check("held_start_pulses", 64'(start_count - rec), 1);

        stub_delay = TO;
        issue(START, 0, 0);
        idle(TO + 4);
        issue(STATUS, 0, 0);
        check("done_at_timeout", uo_out, 8'h40);
        stub_delay = TO + 1;
        issue(START, 0, 0);
        idle(TO + 4);
        issue(STATUS, 0, 0);
        check("done_after_timeout", uo_out, 8'h20);

        stub_delay = 4;
        issue(START, 0, 0);
        #1 rst_n = 1'b0;
        #1 check("async_reset_start", arr_start, 1'b0);
        check("async_reset_w", arr_w, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        idle(6);
        issue(STATUS, 0, 0);
        check("late_done_ignored", uo_out, 8'h00);

        stub_noise = 1; rand_res = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n  = ($urandom_range(0, 499) != 0);
            ena    = ($urandom_range(0, 9) != 0);
            ui_in  = 8'($urandom);
            ui_in[7] = ($urandom_range(0, 3) != 0);
            uio_in = 8'($urandom);
            if ($urandom_range(0, 19) == 0) stub_delay = $urandom_range(0, TO + 2);
        end
        @(negedge clk);
        ui_in = 8'h00; rst_n = 1'b1; stub_noise = 0;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
